// File: rtl/echo_distance_meter.sv
// Ultrasonic echo pulse-width meter: times the synchronized echo-high interval
// after a trigger and reports it in whole centimetres, saturating at MAX_CM.
module echo_distance_meter #(
    parameter int CYCLES_PER_CM = 2900,
    parameter int MAX_CM        = 400,
    parameter int RISE_TIMEOUT  = 1500000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    input  logic       echo,
    output logic [8:0] distance_cm,
    output logic       dist_valid,
    output logic       over_range,
    output logic       timeout,
    output logic       busy
);

    localparam int WAIT_W = (RISE_TIMEOUT  > 1) ? $clog2(RISE_TIMEOUT + 1)  : 1;
    localparam int SUB_W  = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM + 1) : 1;
    localparam int CM_W   = (MAX_CM        > 1) ? $clog2(MAX_CM + 1)        : 1;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RISE_TIMEOUT - 1);
    localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(CYCLES_PER_CM - 1);
    localparam logic [CM_W-1:0]   CM_LAST   = CM_W'(MAX_CM - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_LOW,
        S_WAIT_RISE,
        S_MEASURE,
        S_WAIT_FALL
    } state_t;

    state_t            r_state, w_state_nxt;
    logic              r_echo_m, r_echo_s;
    logic [WAIT_W-1:0] r_wait, w_wait_nxt;
    logic [SUB_W-1:0]  r_sub, w_sub_nxt;
    logic [CM_W-1:0]   r_cm, w_cm_nxt;
    logic [8:0]        r_dist, w_dist_nxt;
    logic              r_over, w_over_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_to, w_to_nxt;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_echo_m <= 1'b0;
            r_echo_s <= 1'b0;
            r_wait   <= '0;
            r_sub    <= '0;
            r_cm     <= '0;
            r_dist   <= '0;
            r_over   <= 1'b0;
            r_valid  <= 1'b0;
            r_to     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_echo_m <= echo;
            r_echo_s <= r_echo_m;
            r_wait   <= w_wait_nxt;
            r_sub    <= w_sub_nxt;
            r_cm     <= w_cm_nxt;
            r_dist   <= w_dist_nxt;
            r_over   <= w_over_nxt;
            r_valid  <= w_valid_nxt;
            r_to     <= w_to_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        w_sub_nxt   = r_sub;
        w_cm_nxt    = r_cm;
        w_dist_nxt  = r_dist;
        w_over_nxt  = r_over;
        w_valid_nxt = 1'b0;
        w_to_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_wait_nxt  = '0;
                    w_state_nxt = r_echo_s ? S_WAIT_LOW : S_WAIT_RISE;
                end
            end
            S_WAIT_LOW: begin
                // A still-high echo from a previous ping must drop before we arm.
                if (r_wait == WAIT_LAST) begin
                    w_to_nxt    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_wait_nxt = r_wait + 1'b1;
                    if (!r_echo_s)
                        w_state_nxt = S_WAIT_RISE;
                end
            end
            S_WAIT_RISE: begin
                if (r_echo_s) begin
                    // The rising cycle is itself the first high cycle.
                    w_sub_nxt   = SUB_W'(1);
                    w_cm_nxt    = '0;
                    w_state_nxt = S_MEASURE;
                end else if (r_wait == WAIT_LAST) begin
                    w_to_nxt    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_wait_nxt = r_wait + 1'b1;
                end
            end
            S_MEASURE: begin
                if (!r_echo_s) begin
                    w_dist_nxt  = 9'(r_cm);
                    w_over_nxt  = 1'b0;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_sub == SUB_LAST) begin
                    w_sub_nxt = '0;
                    w_cm_nxt  = r_cm + 1'b1;
                    if (r_cm == CM_LAST)
                        w_state_nxt = S_WAIT_FALL;
                end else begin
                    w_sub_nxt = r_sub + 1'b1;
                end
            end
            S_WAIT_FALL: begin
                if (!r_echo_s) begin
                    w_dist_nxt  = 9'(MAX_CM);
                    w_over_nxt  = 1'b1;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign distance_cm = r_dist;
    assign dist_valid  = r_valid;
    assign over_range  = r_over;
    assign timeout     = r_to;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_echo_distance_meter.sv
// Randomized bench for echo_distance_meter with a pulse-width reference model,
// using scaled-down parameters so every scenario stays short.
module tb_echo_distance_meter;

    localparam int CPC  = 10;
    localparam int MAXC = 20;
    localparam int RT   = 400;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       echo;
    logic [8:0] distance_cm;
    logic       dist_valid;
    logic       over_range;
    logic       timeout;
    logic       busy;

    int n_pass  = 0;
    int n_total = 0;

    int n_valid = 0;
    int n_to    = 0;
    int n_both  = 0;
    int cap_dist = -1;
    int cap_over = -1;
    int cap_busy = -1;

    echo_distance_meter #(
        .CYCLES_PER_CM(CPC),
        .MAX_CM       (MAXC),
        .RISE_TIMEOUT (RT)
    ) dut (
        .CLOCK_50   (clk),
        .reset      (rst),
        .start      (start),
        .echo       (echo),
        .distance_cm(distance_cm),
        .dist_valid (dist_valid),
        .over_range (over_range),
        .timeout    (timeout),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dist_valid) begin
            n_valid  <= n_valid + 1;
            cap_dist <= int'(distance_cm);
            cap_over <= int'(over_range);
            cap_busy <= int'(busy);
        end
        if (timeout)
            n_to <= n_to + 1;
        if (dist_valid && timeout)
            n_both <= n_both + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference: whole centimetres of high time, clamped at the saturation distance.
    function automatic int ref_dist(input int h);
        return (h >= MAXC * CPC) ? MAXC : h / CPC;
    endfunction

    function automatic int ref_over(input int h);
        return (h >= MAXC * CPC) ? 1 : 0;
    endfunction

    task automatic run_meas(input int stale, input int dly, input int h, input bit extra,
                            input string tag);
        int v0, t0, n;
        v0 = n_valid;
        t0 = n_to;
        if (stale > 0) begin
            echo = 1'b1;
            repeat (4) cyc();
        end
        start = 1'b1;
        cyc();
        start = 1'b0;
        if (stale > 0) begin
            repeat (stale) cyc();
            echo = 1'b0;
        end
        repeat (dly) cyc();
        echo = 1'b1;
        for (int i = 0; i < h; i++) begin
            start = extra && (i == h / 2);
            cyc();
        end
        start = 1'b0;
        chk({tag, "_early"}, n_valid - v0, 0);
        echo = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            cyc();
            n++;
        end
        repeat (2) cyc();
        chk({tag, "_settle"}, int'(busy), 0);
        chk({tag, "_nvalid"}, n_valid - v0, 1);
        chk({tag, "_nto"}, n_to - t0, 0);
        chk({tag, "_dist"}, cap_dist, ref_dist(h));
        chk({tag, "_over"}, cap_over, ref_over(h));
        chk({tag, "_busy"}, cap_busy, 0);
    endtask

    initial begin
        int v0, t0, n, d0, s, dl, h;
        bit ex;
        rst   = 1'b1;
        start = 1'b0;
        echo  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dist", int'(distance_cm), 0);
        chk("rst_valid", int'(dist_valid), 0);
        chk("rst_over", int'(over_range), 0);
        chk("rst_to", int'(timeout), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        repeat (5) cyc();
        chk("idle_busy", int'(busy), 0);

        run_meas(0, 100, 10 * CPC, 0, "nominal");
        run_meas(0, 7, CPC - 1, 0, "b_cpcm1");
        run_meas(0, 7, CPC, 0, "b_cpc");
        run_meas(0, 3, 1, 0, "b_one");
        run_meas(0, 9, MAXC * CPC - 1, 0, "b_maxm1");
        run_meas(0, 9, MAXC * CPC, 0, "b_max");
        run_meas(0, 9, MAXC * CPC + 150, 0, "sat");

        // No echo at all: expect a single timeout pulse RT cycles after start.
        v0 = n_valid;
        t0 = n_to;
        d0 = int'(distance_cm);
        start = 1'b1;
        cyc();
        start = 1'b0;
        n = 0;
        while (!timeout && n < RT + 20) begin
            cyc();
            n++;
        end
        chk("to_latency", (n >= RT - 3 && n <= RT + 3) ? RT : n, RT);
        cyc();
        chk("to_width", int'(timeout), 0);
        chk("to_busy", int'(busy), 0);
        repeat (2) cyc();
        chk("to_count", n_to - t0, 1);
        chk("to_novalid", n_valid - v0, 0);
        chk("to_dist_kept", int'(distance_cm), d0);

        run_meas(30, 5, 2 * CPC, 1, "stale_extra");

        // Reset in the middle of a measurement throws it away.
        v0 = n_valid;
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (5) cyc();
        echo = 1'b1;
        repeat (100) cyc();
        chk("mid_busy_before", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk("mid_dist", int'(distance_cm), 0);
        chk("mid_valid", int'(dist_valid), 0);
        chk("mid_over", int'(over_range), 0);
        chk("mid_to", int'(timeout), 0);
        chk("mid_busy", int'(busy), 0);
        cyc();
        echo = 1'b0;
        cyc();
        rst = 1'b0;
        repeat (6) cyc();
        chk("mid_novalid", n_valid - v0, 0);
        chk("mid_idle", int'(busy), 0);
        run_meas(0, 10, 7 * CPC + 3, 0, "after_rst");

        for (int k = 0; k < 25; k++) begin
            s  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 80)) : 0;
            dl = int'($urandom_range(2, 80));
            h  = int'($urandom_range(1, MAXC * CPC + 30));
            ex = 1'($urandom_range(0, 1));
            run_meas(s, dl, h, ex, $sformatf("rnd%0d_h%0d", k, h));
        end

        chk("never_both", n_both, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/echo_distance_meter.md
ECHO_DISTANCE_METER -- requirements
Module: echo_distance_meter

Interface
REQ-001 The block SHALL have parameter CYCLES_PER_CM, default 2900, meaning the echo-high clock cycles per centimetre (58 us at 50 MHz).
REQ-002 The block SHALL have parameter MAX_CM, default 400, meaning the saturation distance in cm.
REQ-003 The block SHALL have parameter RISE_TIMEOUT, default 1500000, meaning the maximum cycles to wait for an echo rise after start (30 ms).
REQ-004 The block SHALL have port CLOCK_50  input  1  system clock; all state changes occur on its rising edge.
REQ-005 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port start  input  1  one-cycle pulse from the trigger stage marking that a trigger pulse was issued.
REQ-007 The block SHALL have port echo  input  1  raw, asynchronous echo line from the sensor GPIO.
REQ-008 The block SHALL have port distance_cm  output  9  last measured distance, 0..MAX_CM.
REQ-009 The block SHALL have port dist_valid  output  1  one-cycle pulse when distance_cm is updated.
REQ-010 The block SHALL have port over_range  output  1  level, qualified with dist_valid; set when the last result saturated at MAX_CM.
REQ-011 The block SHALL have port timeout  output  1  one-cycle pulse when no echo rise arrives within RISE_TIMEOUT.
REQ-012 The block SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-013 The block SHALL pass echo through a 2-flop synchronizer (echo_s); all decisions use echo_s, so echo_s lags echo by 2 cycles.
REQ-014 The FSM SHALL have the states IDLE, WAIT_LOW, WAIT_RISE, MEASURE and WAIT_FALL.
REQ-015 IDLE: on start=1, the FSM SHALL go to WAIT_LOW if echo_s=1, otherwise to WAIT_RISE; the wait counter SHALL be cleared.
REQ-016 WAIT_LOW: the FSM SHALL stay while echo_s=1 (stale echo) and go to WAIT_RISE when echo_s=0; the wait counter SHALL keep counting.
REQ-017 WAIT_RISE: the wait counter SHALL increment each cycle; on echo_s=1 the FSM SHALL go to MEASURE with sub_cnt set to 1 and cm_cnt set to 0, so the first high cycle counts.
REQ-018 In WAIT_LOW or WAIT_RISE, when the wait counter reaches RISE_TIMEOUT-1 without a rise, the block SHALL pulse timeout for 1 cycle on the next cycle, leave distance_cm unchanged and return to IDLE.
REQ-019 MEASURE, while echo_s=1: sub_cnt SHALL increment; when sub_cnt=CYCLES_PER_CM-1 it SHALL wrap to 0 and cm_cnt SHALL increment.
REQ-020 MEASURE: when cm_cnt would reach MAX_CM, the FSM SHALL go to WAIT_FALL, and cm_cnt SHALL never exceed MAX_CM.
REQ-021 MEASURE: on echo_s=0, on the next edge the block SHALL set distance_cm to cm_cnt, clear over_range, pulse dist_valid for 1 cycle and go to IDLE.
REQ-022 The result SHALL equal floor(H / CYCLES_PER_CM), where H is the number of cycles echo_s was high.
REQ-023 WAIT_FALL: on echo_s=0, the block SHALL set distance_cm to MAX_CM, set over_range, pulse dist_valid and go to IDLE.
REQ-024 WAIT_FALL: the block SHALL have no timeout, because the sensor always drops echo.
REQ-025 start SHALL be ignored in every state except IDLE, with no queuing.
REQ-026 dist_valid and timeout SHALL never be high in the same cycle, and each SHALL be high for exactly 1 cycle per measurement.
REQ-027 Counter widths SHALL be sized from the parameters (ceil log2), with no wrap of the wait counter before RISE_TIMEOUT.

Reset
REQ-028 Asserting reset at any time SHALL immediately force the FSM to IDLE and clear all counters and synchronizer flops.
REQ-029 Asserting reset at any time SHALL force distance_cm=0, dist_valid=0, over_range=0, timeout=0 and busy=0.
REQ-030 Reset asserted mid-measurement SHALL discard the measurement with no dist_valid pulse.
REQ-031 After reset deasserts, the block SHALL wait in IDLE for the next start.

Verification
REQ-032 Nominal: start, echo high 29000 cycles starting 100 cycles later -> dist_valid pulses once; distance_cm=10; over_range=0; busy falls with it.
REQ-033 Boundary: echo high 2899 cycles -> distance_cm=0; echo high 2900 cycles -> distance_cm=1.
REQ-034 Saturation: echo high 2,000,000 cycles -> no pulse until echo falls, then distance_cm=400 and over_range=1.
REQ-035 Timeout: start with echo held low -> timeout pulses exactly 1,500,000 cycles after start (within ±3); distance_cm keeps its previous value; dist_valid stays 0.
REQ-036 Stale echo and start while busy: echo already high at start -> echo falls, then a 5800-cycle pulse measures 2; a second start during MEASURE -> ignored, exactly one dist_valid.
REQ-037 Reset mid-measurement: reset at cycle 10000 of a 29000-cycle echo -> outputs 0 immediately, no dist_valid; the next start measures correctly.
